// File: rtl/param_sync_counter.sv
// Fully synchronous up/down modulo counter with parallel load, wrap/saturate
// boundary handling and event flags. Define PARAM_SYNC_COUNTER_GRAY_EN to add count_gray.
module param_sync_counter #(
  parameter int WIDTH    = 4,
  parameter int MOD      = 16,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             at_sat
`ifdef PARAM_SYNC_COUNTER_GRAY_EN
  ,
  output logic [WIDTH-1:0] count_gray
`endif
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ZERO    = '0;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic             SAT_EN  = (SATURATE != 0);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             at_sat_q, at_sat_d;
  logic             at_top, at_bottom;

  assign at_top    = (count_q == MAX_VAL);
  assign at_bottom = (count_q == ZERO);

  // tc looks one edge ahead: it is high in the cycle before a boundary event.
  assign tc = en & ((up_dn & at_top) | (~up_dn & at_bottom));

  always_comb begin
    count_d  = count_q;
    wrap_d   = 1'b0;
    at_sat_d = at_sat_q;
    if (load) begin
      count_d  = (load_val > MAX_VAL) ? MAX_VAL : load_val;
      at_sat_d = 1'b0;
    end else if (en) begin
      if (tc) begin
        wrap_d   = 1'b1;
        at_sat_d = SAT_EN;
        if (!SAT_EN) begin
          count_d = up_dn ? ZERO : MAX_VAL;
        end
      end else begin
        count_d  = up_dn ? (count_q + ONE) : (count_q - ONE);
        at_sat_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      wrap_q   <= 1'b0;
      at_sat_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wrap_q   <= wrap_d;
      at_sat_q <= at_sat_d;
    end
  end

  assign count  = count_q;
  assign wrap   = wrap_q;
  assign at_sat = at_sat_q;

`ifdef PARAM_SYNC_COUNTER_GRAY_EN
  logic [WIDTH-1:0] gray_q;

  // Encoding the next count keeps count_gray aligned with count in every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      gray_q <= '0;
    end else begin
      gray_q <= count_d ^ (count_d >> 1);
    end
  end

  assign count_gray = gray_q;
`endif

endmodule

// File: tb/tb_param_sync_counter.sv
// Directed bench for param_sync_counter: three instances (wrap mod 16, wrap mod 10,
// saturate mod 10) share one stimulus stream and are checked against a modular-arithmetic model.
module tb_param_sync_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic up_dn = 1'b0;
  logic load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [2:0][3:0] cnt;
  logic [2:0] tcv;
  logic [2:0] wr;
  logic [2:0] sat;
`ifdef PARAM_SYNC_COUNTER_GRAY_EN
  logic [2:0][3:0] gry;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  param_sync_counter #(.WIDTH(4), .MOD(16), .SATURATE(0)) dutA (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(cnt[0]), .tc(tcv[0]), .wrap(wr[0]), .at_sat(sat[0])
`ifdef PARAM_SYNC_COUNTER_GRAY_EN
    , .count_gray(gry[0])
`endif
  );

  param_sync_counter #(.WIDTH(4), .MOD(10), .SATURATE(0)) dutB (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(cnt[1]), .tc(tcv[1]), .wrap(wr[1]), .at_sat(sat[1])
`ifdef PARAM_SYNC_COUNTER_GRAY_EN
    , .count_gray(gry[1])
`endif
  );

  param_sync_counter #(.WIDTH(4), .MOD(10), .SATURATE(1)) dutC (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(cnt[2]), .tc(tcv[2]), .wrap(wr[2]), .at_sat(sat[2])
`ifdef PARAM_SYNC_COUNTER_GRAY_EN
    , .count_gray(gry[2])
`endif
  );

  function automatic int modOf(int i);
    return (i == 0) ? 16 : 10;
  endfunction

  function automatic bit satOf(int i);
    return (i == 2);
  endfunction

  function automatic string tag(int i);
    return (i == 0) ? "A" : ((i == 1) ? "B" : "C");
  endfunction

  task automatic checkOutput(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Behavioural model: modular or clamped arithmetic on plain integers.
  int  mc[3];
  int  prevMc[3];
  bit  mw[3];
  bit  ms[3];
  bit  mvalid = 1'b0;
  int  mMod;
  int  mNext;
  bit  mTc;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      mMod = modOf(i);
      mTc  = en && ((up_dn && mc[i] == mMod - 1) || (!up_dn && mc[i] == 0));
      prevMc[i] = mc[i];
      if (rst) begin
        mc[i] = 0; mw[i] = 0; ms[i] = 0;
      end else if (load) begin
        mc[i] = (int'(load_val) < mMod) ? int'(load_val) : mMod - 1;
        mw[i] = 0; ms[i] = 0;
      end else if (en) begin
        mw[i] = mTc;
        if (satOf(i)) begin
          mNext = mc[i] + (up_dn ? 1 : -1);
          if (mNext < 0) mNext = 0;
          if (mNext > mMod - 1) mNext = mMod - 1;
          ms[i] = mTc;
        end else begin
          mNext = (mc[i] + (up_dn ? 1 : mMod - 1)) % mMod;
          ms[i] = 0;
        end
        mc[i] = mNext;
      end else begin
        mw[i] = 0;
      end
    end
    if (rst) mvalid = 1'b1;
  end

  // Continuous comparison of every instance against the model.
  always @(negedge clk) begin
    if (mvalid) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput({tag(i), ".count"}, int'(cnt[i]), mc[i]);
        checkOutput({tag(i), ".tc"}, int'(tcv[i]),
                    int'(en && ((up_dn && mc[i] == modOf(i) - 1) || (!up_dn && mc[i] == 0))));
        checkOutput({tag(i), ".wrap"}, int'(wr[i]), int'(mw[i]));
        checkOutput({tag(i), ".at_sat"}, int'(sat[i]), int'(ms[i]));
        checkOutput({tag(i), ".in_range"}, int'(int'(cnt[i]) < modOf(i)), 1);
`ifdef PARAM_SYNC_COUNTER_GRAY_EN
        checkOutput({tag(i), ".count_gray"}, int'(gry[i]), mc[i] ^ (mc[i] >> 1));
`endif
      end
`ifdef PARAM_SYNC_COUNTER_GRAY_EN
      if (mc[0] == ((prevMc[0] + 1) % 16) || prevMc[0] == ((mc[0] + 1) % 16))
        checkOutput("A.gray_one_bit",
                    $countones(4'(mc[0] ^ (mc[0] >> 1)) ^ 4'(prevMc[0] ^ (prevMc[0] >> 1))), 1);
`endif
    end
  end

  task automatic applyStimulus(bit r, bit l, int lv, bit e, bit u, int n);
    rst = r; load = l; load_val = 4'(lv); en = e; up_dn = u;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 2);
    checkOutput("reset.A.count", int'(cnt[0]), 0);
    checkOutput("reset.A.wrap", int'(wr[0]), 0);
    checkOutput("reset.C.at_sat", int'(sat[2]), 0);

    applyStimulus(0, 0, 0, 1, 1, 15);
    checkOutput("up.A.count15", int'(cnt[0]), 15);
    checkOutput("up.A.tc15", int'(tcv[0]), 1);
    applyStimulus(0, 0, 0, 1, 1, 1);
    checkOutput("up.A.wrapto0", int'(cnt[0]), 0);
    checkOutput("up.A.wrap", int'(wr[0]), 1);
    applyStimulus(0, 0, 0, 1, 1, 1);
    checkOutput("up.A.count1", int'(cnt[0]), 1);

    applyStimulus(1, 0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 1);
    checkOutput("down.B.count9", int'(cnt[1]), 9);
    checkOutput("down.B.wrap", int'(wr[1]), 1);
    checkOutput("down.C.held0", int'(cnt[2]), 0);
    checkOutput("down.C.at_sat", int'(sat[2]), 1);
    applyStimulus(0, 0, 0, 1, 0, 11);

    applyStimulus(0, 1, 7, 0, 1, 1);
    checkOutput("sat.C.load7", int'(cnt[2]), 7);
    checkOutput("sat.C.at_sat_load", int'(sat[2]), 0);
    applyStimulus(0, 0, 0, 1, 1, 2);
    checkOutput("sat.C.count9", int'(cnt[2]), 9);
    applyStimulus(0, 0, 0, 1, 1, 1);
    checkOutput("sat.C.held9", int'(cnt[2]), 9);
    checkOutput("sat.C.at_sat", int'(sat[2]), 1);
    checkOutput("sat.C.wrap", int'(wr[2]), 1);
    applyStimulus(0, 0, 0, 1, 1, 2);
    applyStimulus(0, 0, 0, 1, 0, 1);
    checkOutput("sat.C.stepdown", int'(cnt[2]), 8);
    checkOutput("sat.C.at_sat_clear", int'(sat[2]), 0);

    applyStimulus(0, 1, 12, 0, 1, 1);
    checkOutput("load.A.12", int'(cnt[0]), 12);
    checkOutput("load.B.clamp", int'(cnt[1]), 9);
    checkOutput("load.C.clamp", int'(cnt[2]), 9);

    applyStimulus(0, 1, 3, 1, 1, 1);
    checkOutput("loaden.A.count", int'(cnt[0]), 3);
    checkOutput("loaden.B.count", int'(cnt[1]), 3);
    checkOutput("loaden.A.wrap", int'(wr[0]), 0);

    applyStimulus(0, 0, 0, 1, 1, 2);
    checkOutput("mid.A.count5", int'(cnt[0]), 5);
`ifdef PARAM_SYNC_COUNTER_GRAY_EN
    checkOutput("mid.A.gray7", int'(gry[0]), 7);
`endif
    applyStimulus(1, 0, 0, 1, 1, 1);
    checkOutput("rstmid.A.count", int'(cnt[0]), 0);
    checkOutput("rstmid.A.wrap", int'(wr[0]), 0);
    applyStimulus(0, 0, 0, 1, 1, 2);
    checkOutput("resume.A.count2", int'(cnt[0]), 2);

    applyStimulus(1, 1, 5, 1, 1, 1);
    checkOutput("rstload.A.count", int'(cnt[0]), 0);
    applyStimulus(0, 0, 0, 0, 1, 2);
    checkOutput("idle.A.hold", int'(cnt[0]), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
